// File: rtl/sram_init_pkg.sv
// Shared types and geometry helpers for the banked, self-initialising 1R1W SRAM.
package sram_init_pkg;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_t;

   function automatic int bank_w(input int num_banks);
      return $clog2(num_banks);
   endfunction

   function automatic int row_w(input int addr_w, input int num_banks);
      return addr_w - $clog2(num_banks);
   endfunction

   function automatic int rows(input int addr_w, input int num_banks);
      return (1 << addr_w) / num_banks;
   endfunction

   // Zero-width fields (one bank, or one row per bank) still need a 1-bit vector.
   function automatic int at_least_one(input int w);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/sram_1r1w_bank.sv
// One SRAM bank: synchronous write, registered read-first read port.
module sram_1r1w_bank #(
   parameter int ROW_W  = 4,
   parameter int DATA_W = 112
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ROW_W-1:0]  wr_row,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ROW_W-1:0]  rd_row,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [0:(1<<ROW_W)-1];

   // NOTE: the array has no reset; the init sequencer writes every row before any read.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_row] <= wr_data;
   end

   // NOTE: non-blocking assignments make a same-edge read return the pre-write contents.
   always_ff @(posedge clk) begin
      if (rst)        rd_data <= '0;
      else if (rd_en) rd_data <= mem[rd_row];
   end

endmodule

// File: rtl/sram_banked_init_ctrl.sv
// Banked 1R1W SRAM with a hardware fill sequencer, latched re-init mask and zero-detect read port.
module sram_banked_init_ctrl
   import sram_init_pkg::*;
#(
   parameter int                DATA_W     = 112,
   parameter int                ADDR_W     = 5,
   parameter int                NUM_BANKS  = 2,
   parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 init_req,
   input  logic [NUM_BANKS-1:0] init_bank_mask,
   output logic                 init_busy,
   output logic                 init_done,
   output logic                 req_ready,
   input  logic                 wr_en,
   input  logic [ADDR_W-1:0]    wr_addr,
   input  logic [DATA_W-1:0]    wr_data,
   input  logic                 rd_en,
   input  logic [ADDR_W-1:0]    rd_addr,
   output logic                 rd_valid,
   output logic [DATA_W-1:0]    rd_data,
   output logic                 rd_is_zero
);

   localparam int BANK_W   = bank_w(NUM_BANKS);
   localparam int ROW_W    = row_w(ADDR_W, NUM_BANKS);
   localparam int ROWS     = rows(ADDR_W, NUM_BANKS);
   localparam int BANK_W_I = at_least_one(BANK_W);
   localparam int ROW_W_I  = at_least_one(ROW_W);

   state_t                state_q, state_d;
   logic [ROW_W_I-1:0]    row_cnt_q;
   logic [NUM_BANKS-1:0]  mask_q;
   logic                  init_done_q, rd_valid_q;
   logic [BANK_W_I-1:0]   rd_bank_q, wr_bank, rd_bank;
   logic [ROW_W_I-1:0]    wr_row, rd_row;
   logic                  ready, last_row, start;
   logic [DATA_W-1:0]     bank_rd [NUM_BANKS];

   assign ready    = (state_q == ST_READY);
   assign last_row = (row_cnt_q == ROW_W_I'(ROWS - 1));
   assign start    = init_req && |init_bank_mask;

   // Low address bits pick the bank so consecutive addresses interleave across banks.
   if (BANK_W > 0) begin : g_bank_dec
      assign wr_bank = wr_addr[BANK_W-1:0];
      assign rd_bank = rd_addr[BANK_W-1:0];
   end else begin : g_one_bank
      assign wr_bank = '0;
      assign rd_bank = '0;
   end

   if (ROW_W > 0) begin : g_row_dec
      assign wr_row = wr_addr[ADDR_W-1:BANK_W];
      assign rd_row = rd_addr[ADDR_W-1:BANK_W];
   end else begin : g_one_row
      assign wr_row = '0;
      assign rd_row = '0;
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_INIT;
      else     state_q <= state_d;
   end

   // NOTE: default assignment first so no path through the case leaves state_d unassigned (no latch).
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_INIT:  if (last_row) state_d = ST_READY;
         ST_READY: if (start)    state_d = ST_INIT;
         default:                state_d = ST_INIT;
      endcase
   end

   always_comb begin
      init_busy = (state_q == ST_INIT);
      req_ready = (state_q == ST_READY);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         row_cnt_q   <= '0;
         mask_q      <= '1;
         init_done_q <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_bank_q   <= '0;
      end else begin
         rd_valid_q <= ready && rd_en;
         if (ready && rd_en) rd_bank_q <= rd_bank;
         if (!ready) begin
            row_cnt_q <= row_cnt_q + 1'b1;
            if (last_row) init_done_q <= 1'b1;
         end else if (start) begin
            row_cnt_q <= '0;
            mask_q    <= init_bank_mask;
         end
      end
   end

   // During INIT the sequencer owns every bank write port; user traffic is dropped.
   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      logic bank_we, bank_re;

      assign bank_we = !rst && (ready ? (wr_en && (wr_bank == BANK_W_I'(b))) : mask_q[b]);
      assign bank_re = !rst && ready && rd_en && (rd_bank == BANK_W_I'(b));

      sram_1r1w_bank #(
         .ROW_W  (ROW_W_I),
         .DATA_W (DATA_W)
      ) u_bank (
         .clk     (clk),
         .rst     (rst),
         .wr_en   (bank_we),
         .wr_row  (ready ? wr_row : row_cnt_q),
         .wr_data (ready ? wr_data : INIT_VALUE),
         .rd_en   (bank_re),
         .rd_row  (rd_row),
         .rd_data (bank_rd[b])
      );
   end

   assign init_done  = init_done_q;
   assign rd_valid   = rd_valid_q;
   assign rd_data    = bank_rd[rd_bank_q];
   assign rd_is_zero = (rd_data == '0);

endmodule
